// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operation and result bus between the datapath controller and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             Verflow;
    logic             Carry;
    logic             Negative;
    logic             Zero;

    modport master (
        output in_valid, A, B, control, out_ready,
        input  in_ready, out_valid, result, Verflow, Carry, Negative, Zero
    );

    modport slave (
        input  in_valid, A, B, control, out_ready,
        output in_ready, out_valid, result, Verflow, Carry, Negative, Zero
    );

endinterface

// File: rtl/alu_flags.sv
// Combinational V/C/N/Z from the opcode, operand signs, adder carry-out and final result.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              i_op,
    input  logic             i_a_msb,
    input  logic             i_b_msb,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_cout,
    input  logic             i_sll_c,
    input  logic             i_mul_nz,
    output logic [3:0]       o_flags
);

    logic w_res_msb;
    assign w_res_msb = i_res[WIDTH-1];

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = w_res_msb;
        o_flags[FLAG_Z] = (i_res == '0);
        case (i_op)
            OP_ADD: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = (i_a_msb == i_b_msb) && (w_res_msb != i_a_msb);
            end
            OP_SUB: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = (i_a_msb != i_b_msb) && (w_res_msb != i_a_msb);
            end
            OP_SLL: o_flags[FLAG_C] = i_sll_c;
            OP_MUL: begin
                o_flags[FLAG_C] = i_mul_nz;
                o_flags[FLAG_V] = i_mul_nz;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with iterative shifter and shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 111 returns 0 in one cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_result;
    logic [SHW:0]     r_cnt;
    logic [3:0]       r_flags;
    logic             r_out_valid;

    logic             w_start;
    op_e              w_in_op;
    op_e              w_op;
    logic [WIDTH-1:0] w_a;
    logic [SHW:0]     w_cnt;
    logic             w_sub;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;
    logic             w_iter;
    logic             w_last;
    logic [WIDTH-1:0] w_res;
    logic             w_sll_c;
    logic             w_mul_nz;
    logic [3:0]       w_flags;

    assign bus.in_ready = (r_state == IDLE) || (r_state == DONE && bus.out_ready);
    assign w_start      = bus.in_valid && bus.in_ready;
    assign w_in_op      = op_e'(bus.control);

    // The transfer edge already performs the first iteration, so operands come straight
    // from the bus on that cycle and from the working registers afterwards.
    assign w_op  = w_start ? w_in_op : r_op;
    assign w_a   = w_start ? bus.A : r_a;
    assign w_cnt = w_start ? ((w_in_op == OP_SLL) ? {1'b0, bus.B[SHW-1:0]} : (SHW+1)'(WIDTH))
                           : r_cnt;

    assign w_sub = (w_in_op == OP_SUB);
    assign w_bop = w_sub ? ~bus.B : bus.B;
    assign w_sum = {1'b0, bus.A} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // {hi,lo} starts as {0,B}; each step adds A into hi on lo[0] and shifts right.
    assign w_hi     = w_start ? '0 : r_hi;
    assign w_lo     = w_start ? bus.B : r_lo;
    assign w_madd   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_a} : '0);
    assign w_hi_nxt = w_madd[WIDTH:1];
    assign w_lo_nxt = {w_madd[0], w_lo[WIDTH-1:1]};
    assign w_iter   = (w_op == OP_SLL && w_cnt != '0) || (w_op == OP_MUL);
`else
    assign w_iter   = (w_op == OP_SLL && w_cnt != '0);
`endif

    assign w_last = !w_iter || (w_cnt == (SHW+1)'(1));

    always_comb begin
        w_res    = '0;
        w_sll_c  = 1'b0;
        w_mul_nz = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: w_res = w_sum[WIDTH-1:0];
            OP_AND:         w_res = bus.A & bus.B;
            OP_OR:          w_res = bus.A | bus.B;
            OP_XOR:         w_res = bus.A ^ bus.B;
            OP_SLT:         w_res = WIDTH'($signed(bus.A) < $signed(bus.B));
            OP_SLL: begin
                if (w_iter) begin
                    w_res   = w_a << 1;
                    w_sll_c = w_a[WIDTH-1];
                end else begin
                    w_res   = w_a;
                end
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                w_res    = w_lo_nxt;
                w_mul_nz = |w_hi_nxt;
`else
                w_res    = '0;
`endif
            end
            default: w_res = '0;
        endcase
    end

    alu_flags #(.WIDTH(WIDTH)) u_flags (
        .i_op     (w_op),
        .i_a_msb  (bus.A[WIDTH-1]),
        .i_b_msb  (bus.B[WIDTH-1]),
        .i_res    (w_res),
        .i_cout   (w_sum[WIDTH]),
        .i_sll_c  (w_sll_c),
        .i_mul_nz (w_mul_nz),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_hi        <= '0;
            r_lo        <= '0;
`endif
        end else if (w_start || r_state == EXEC) begin
            r_op  <= w_op;
            r_a   <= (w_op == OP_SLL) ? (w_a << 1) : w_a;
            r_cnt <= w_last ? '0 : (w_cnt - (SHW+1)'(1));
`ifdef ALU_SEQ_MUL_EN
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
`endif
            if (w_last) begin
                r_result    <= w_res;
                r_flags     <= w_flags;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
            end else begin
                r_out_valid <= 1'b0;
                r_state     <= EXEC;
            end
        end else if (r_state == DONE && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.Verflow   = r_flags[FLAG_V];
    assign bus.Carry     = r_flags[FLAG_C];
    assign bus.Negative  = r_flags[FLAG_N];
    assign bus.Zero      = r_flags[FLAG_Z];

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq; MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lat;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.Verflow, bus.Carry, bus.Negative, bus.Zero};
    endfunction

    // Issue one op from IDLE, scramble the inputs after transfer, count edges to out_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        bus.control  = op;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 32'hDEAD_BEEF;
        bus.B        = 32'h1234_5677;
        bus.control  = 3'b010;
        cycles = 1;
        while (bus.out_valid !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("consume_ov", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.control = '0;
        #12;
        chk("rst_ov",     {31'd0, bus.out_valid}, 32'd0);
        chk("rst_res",    bus.result, 32'd0);
        chk("rst_flags",  {28'd0, flags()}, 32'd0);
        chk("rst_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'd50, 32'd60, lat);
        chk("add_lat", lat, 1);
        chk("add_res", bus.result, 32'd110);
        chk("add_flg", {28'd0, flags()}, 32'b0000);
        consume();

        run_op(3'b001, 32'd60, 32'd60, lat);
        chk("sub0_res", bus.result, 32'd0);
        chk("sub0_flg", {28'd0, flags()}, 32'b0101);
        consume();

        run_op(3'b000, 32'h8000_0000, 32'h8000_0001, lat);
        chk("addov_res", bus.result, 32'h0000_0001);
        chk("addov_flg", {28'd0, flags()}, 32'b1100);
        consume();

        run_op(3'b001, 32'd5, 32'd7, lat);
        chk("subbw_res", bus.result, 32'hFFFF_FFFE);
        chk("subbw_flg", {28'd0, flags()}, 32'b0010);
        consume();

        run_op(3'b001, 32'h8000_0000, 32'd1, lat);
        chk("subov_res", bus.result, 32'h7FFF_FFFF);
        chk("subov_flg", {28'd0, flags()}, 32'b1100);
        consume();

        run_op(3'b010, 32'h0000_F0F0, 32'h0000_FF00, lat);
        chk("and_res", bus.result, 32'h0000_F000);
        consume();
        run_op(3'b011, 32'h0000_F0F0, 32'h0000_FF00, lat);
        chk("or_res", bus.result, 32'h0000_FFF0);
        consume();
        run_op(3'b100, 32'h0000_F0F0, 32'h0000_FF00, lat);
        chk("xor_res", bus.result, 32'h0000_0FF0);
        chk("xor_flg", {28'd0, flags()}, 32'b0000);
        consume();

        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, lat);
        chk("slt_t_res", bus.result, 32'd1);
        consume();
        run_op(3'b101, 32'd1, 32'hFFFF_FFFF, lat);
        chk("slt_f_res", bus.result, 32'd0);
        chk("slt_f_flg", {28'd0, flags()}, 32'b0001);
        consume();

        run_op(3'b110, 32'hC000_0001, 32'd4, lat);
        chk("sll4_lat", lat, 4);
        chk("sll4_res", bus.result, 32'h0000_0010);
        chk("sll4_flg", {28'd0, flags()}, 32'b0000);
        consume();

        run_op(3'b110, 32'hC000_0001, 32'd32, lat);
        chk("sll0_lat", lat, 1);
        chk("sll0_res", bus.result, 32'hC000_0001);
        chk("sll0_flg", {28'd0, flags()}, 32'b0010);
        consume();

        run_op(3'b110, 32'h8000_0000, 32'd1, lat);
        chk("sll1_lat", lat, 1);
        chk("sll1_res", bus.result, 32'd0);
        chk("sll1_flg", {28'd0, flags()}, 32'b0101);
        consume();

`ifdef ALU_SEQ_MUL_EN
        run_op(3'b111, 32'h0001_0000, 32'h0001_0000, lat);
        chk("mulhi_lat", lat, 32);
        chk("mulhi_res", bus.result, 32'd0);
        chk("mulhi_flg", {28'd0, flags()}, 32'b1101);
        consume();
        run_op(3'b111, 32'd7, 32'd6, lat);
        chk("mul_lat", lat, 32);
        chk("mul_res", bus.result, 32'd42);
        chk("mul_flg", {28'd0, flags()}, 32'b0000);
        consume();
        run_op(3'b111, 32'd0, 32'd5, lat);
        chk("mul0_lat", lat, 32);
        chk("mul0_res", bus.result, 32'd0);
        consume();
`else
        run_op(3'b111, 32'h0001_0000, 32'h0001_0000, lat);
        chk("nomul_lat", lat, 1);
        chk("nomul_res", bus.result, 32'd0);
        chk("nomul_flg", {28'd0, flags()}, 32'b0001);
        consume();
`endif

        // Result must hold while the consumer stalls, even with a new op offered.
        run_op(3'b000, 32'd3, 32'd4, lat);
        @(negedge clk);
        bus.control  = 3'b000;
        bus.A        = 32'd100;
        bus.B        = 32'd100;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_res", bus.result, 32'd7);
            chk("hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        end
        // Back-to-back: consume and issue in the same cycle.
        @(negedge clk);
        bus.A         = 32'd10;
        bus.B         = 32'd20;
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_rdy", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_ov",  {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_res", bus.result, 32'd30);
        consume();

        // Reset in the middle of an iterative op.
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        bus.control = 3'b111;
`else
        bus.control = 3'b110;
`endif
        bus.A        = 32'hFFFF_FFFF;
        bus.B        = 32'hFFFF_FFF4;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_ov",    {31'd0, bus.out_valid}, 32'd0);
        chk("mid_res",   bus.result, 32'd0);
        chk("mid_flg",   {28'd0, flags()}, 32'd0);
        chk("mid_rdy",   {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'd1, 32'd1, lat);
        chk("post_lat", lat, 1);
        chk("post_res", bus.result, 32'd2);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
